// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU sequencer: FSM state encoding and default result latency.
package tpu_pkg;

   localparam int unsigned TPU_RESULT_LAT = 17;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT_W = 3'd1,
      LOAD_W = 3'd2,
      FEED   = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } tpu_state_e;

endpackage

// File: rtl/tpu_valid_delay.sv
// Fixed-depth 1-bit valid pipeline; aligns UB read valids with result vectors.
module tpu_valid_delay #(
   parameter int unsigned DEPTH = 17
) (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr;

   generate
      if (DEPTH == 1) begin : g_single
         // Single-stage delay
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) sr <= '0;
            else       sr <= din;
         end
      end else begin : g_multi
         // Shift the valid bit one stage per cycle
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) sr <= '0;
            else       sr <= {sr[DEPTH-2:0], din};
         end
      end
   endgenerate

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Job sequencer for the systolic array: pops a weight tile, reloads it row by row,
// streams input vectors from the unified buffer and writes aligned results.
// Optional feature: define TPU_SEQ_PERF_EN to add the 32-bit busy-cycle counter cycle_cnt.
module tpu_seq_ctrl
   import tpu_pkg::*;
#(
   parameter int unsigned ADDRESSSIZE = 10,
   parameter int unsigned NUM_PE_ROWS = 8,
   parameter int unsigned RESULT_LAT  = TPU_RESULT_LAT
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic [ADDRESSSIZE-1:0] in_base,
   input  logic [ADDRESSSIZE-1:0] out_base,
   input  logic [ADDRESSSIZE-1:0] num_vec,
   input  logic                   fifo_empty,
   output logic                   fifo_read_enable,
   output logic                   we_rl,
   output logic [ADDRESSSIZE-1:0] ub_addr,
   output logic                   ub_rd,
   output logic [ADDRESSSIZE-1:0] res_addr,
   output logic                   res_we,
`ifdef TPU_SEQ_PERF_EN
   output logic [31:0]            cycle_cnt,
`endif
   output logic                   busy,
   output logic                   end_
);

   localparam int unsigned LW = $clog2(NUM_PE_ROWS + 1);

   tpu_state_e             state;
   logic [ADDRESSSIZE-1:0] in_base_q;
   logic [ADDRESSSIZE-1:0] num_vec_q;
   logic [LW-1:0]          ld_cnt;
   logic [ADDRESSSIZE-1:0] rd_cnt;
   logic [ADDRESSSIZE-1:0] wr_cnt;

   // Result write enable is the read valid delayed by the array latency
   tpu_valid_delay #(.DEPTH(RESULT_LAT)) u_valid_delay (
      .clk  (clk),
      .rstn (rstn),
      .din  (ub_rd),
      .dout (res_we)
   );

   // Sequencer FSM with registered strobes, addresses and status
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state            <= IDLE;
         in_base_q        <= '0;
         num_vec_q        <= '0;
         ld_cnt           <= '0;
         rd_cnt           <= '0;
         wr_cnt           <= '0;
         fifo_read_enable <= 1'b0;
         we_rl            <= 1'b0;
         ub_rd            <= 1'b0;
         ub_addr          <= '0;
         res_addr         <= '0;
         busy             <= 1'b0;
         end_             <= 1'b0;
      end else begin
         fifo_read_enable <= 1'b0;
         we_rl            <= 1'b0;
         ub_rd            <= 1'b0;
         end_             <= 1'b0;

         // res_addr always points at the next result slot to be written
         if (res_we) begin
            res_addr <= res_addr + ADDRESSSIZE'(1);
            wr_cnt   <= wr_cnt + ADDRESSSIZE'(1);
         end

         case (state)
            IDLE: begin
               if (start) begin
                  in_base_q <= in_base;
                  num_vec_q <= num_vec;
                  res_addr  <= out_base;
                  ld_cnt    <= '0;
                  rd_cnt    <= '0;
                  wr_cnt    <= '0;
                  busy      <= 1'b1;
                  state     <= WAIT_W;
               end
            end
            WAIT_W: begin
               if (!fifo_empty) begin
                  fifo_read_enable <= 1'b1;
                  ld_cnt           <= '0;
                  state            <= LOAD_W;
               end
            end
            LOAD_W: begin
               if (ld_cnt == LW'(NUM_PE_ROWS)) begin
                  if (num_vec_q == '0) begin
                     end_  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= FEED;
                  end
               end else begin
                  we_rl  <= 1'b1;
                  ld_cnt <= ld_cnt + LW'(1);
               end
            end
            FEED: begin
               if (rd_cnt != num_vec_q) begin
                  ub_rd   <= 1'b1;
                  ub_addr <= in_base_q + rd_cnt;
                  rd_cnt  <= rd_cnt + ADDRESSSIZE'(1);
               end else begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (res_we && (wr_cnt == num_vec_q - ADDRESSSIZE'(1))) begin
                  end_  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef TPU_SEQ_PERF_EN
   // Busy-cycle counter: cleared on job acceptance, holds its value while idle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_cnt <= '0;
      end else if ((state == IDLE) && start) begin
         cycle_cnt <= '0;
      end else if (busy) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed self-checking bench for tpu_seq_ctrl.
module tb_tpu_seq_ctrl;

   localparam int unsigned AW   = 10;
   localparam int unsigned ROWS = 8;
   localparam int unsigned LAT  = 17;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic [AW-1:0] in_base;
   logic [AW-1:0] out_base;
   logic [AW-1:0] num_vec;
   logic          fifo_empty;
   logic          fifo_read_enable;
   logic          we_rl;
   logic [AW-1:0] ub_addr;
   logic          ub_rd;
   logic [AW-1:0] res_addr;
   logic          res_we;
   logic          busy;
   logic          end_;
`ifdef TPU_SEQ_PERF_EN
   logic [31:0]   cycle_cnt;
`endif

   always #5 clk = ~clk;

   tpu_seq_ctrl #(.ADDRESSSIZE(AW), .NUM_PE_ROWS(ROWS), .RESULT_LAT(LAT)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .start            (start),
      .in_base          (in_base),
      .out_base         (out_base),
      .num_vec          (num_vec),
      .fifo_empty       (fifo_empty),
      .fifo_read_enable (fifo_read_enable),
      .we_rl            (we_rl),
      .ub_addr          (ub_addr),
      .ub_rd            (ub_rd),
      .res_addr         (res_addr),
      .res_we           (res_we),
`ifdef TPU_SEQ_PERF_EN
      .cycle_cnt        (cycle_cnt),
`endif
      .busy             (busy),
      .end_             (end_)
   );

   // Event monitor, sampled on the falling edge
   int            cyc, n_fre, n_we, we_runs, n_end, n_busy, fre_cyc, end_cyc;
   logic          we_prev = 1'b0;
   int            rd_cyc[$];
   int            wr_cyc[$];
   logic [AW-1:0] rd_addr[$];
   logic [AW-1:0] wr_addr[$];

   always @(negedge clk) begin
      cyc     <= cyc + 1;
      we_prev <= we_rl;
      if (fifo_read_enable) begin
         n_fre   <= n_fre + 1;
         fre_cyc <= cyc;
      end
      if (we_rl)             n_we    <= n_we + 1;
      if (we_rl && !we_prev) we_runs <= we_runs + 1;
      if (ub_rd) begin
         rd_cyc.push_back(cyc);
         rd_addr.push_back(ub_addr);
      end
      if (res_we) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(res_addr);
      end
      if (end_) begin
         n_end   <= n_end + 1;
         end_cyc <= cyc;
      end
      if (busy) n_busy <= n_busy + 1;
   end

   int n_checks = 0;
   int n_errors = 0;
   int b_fre, b_we, b_runs, b_end, b_busy, b_rd, b_wr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic snap();
      b_fre  = n_fre;
      b_we   = n_we;
      b_runs = we_runs;
      b_end  = n_end;
      b_busy = n_busy;
      b_rd   = rd_addr.size();
      b_wr   = wr_addr.size();
   endtask

   task automatic start_job(input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                            input logic [AW-1:0] nv);
      @(posedge clk); #1;
      in_base  = ib;
      out_base = ob;
      num_vec  = nv;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      for (int i = 0; i < budget && n_end == b_end; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_job(input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                            input int nv);
      int nrd, nwr;
      nrd = rd_addr.size() - b_rd;
      nwr = wr_addr.size() - b_wr;
      check("fre_count", 32'(n_fre - b_fre), 32'd1);
      check("we_count", 32'(n_we - b_we), 32'(ROWS));
      check("we_runs", 32'(we_runs - b_runs), 32'd1);
      check("rd_count", 32'(nrd), 32'(nv));
      check("wr_count", 32'(nwr), 32'(nv));
      for (int i = 0; i < nv; i++) begin
         logic [AW-1:0] er, ew;
         er = ib + AW'(i);
         ew = ob + AW'(i);
         if (i < nrd) begin
            check("rd_addr", 32'(rd_addr[b_rd+i]), 32'(er));
            check("rd_gap", 32'(rd_cyc[b_rd+i] - rd_cyc[b_rd]), 32'(i));
         end
         if (i < nwr) check("wr_addr", 32'(wr_addr[b_wr+i]), 32'(ew));
         if (i < nwr && i < nrd)
            check("wr_lat", 32'(wr_cyc[b_wr+i] - rd_cyc[b_rd+i]), 32'(LAT));
      end
      check("end_count", 32'(n_end - b_end), 32'd1);
      if (nv > 0 && nwr > 0)
         check("end_after_wr", 32'(end_cyc - wr_cyc[wr_cyc.size()-1]), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int drop;
      rstn       = 1'b0;
      start      = 1'b0;
      in_base    = '0;
      out_base   = '0;
      num_vec    = '0;
      fifo_empty = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outs", 32'({busy, end_, fifo_read_enable, we_rl, ub_rd, res_we, ub_addr, res_addr}), 32'd0);
      rstn = 1'b1;

      // Basic job
      snap();
      start_job(10'd10, 10'd100, 10'd4);
      wait_end(200);
      check_job(10'd10, 10'd100, 4);

      // Weight FIFO empty for a while after start
      fifo_empty = 1'b1;
      snap();
      start_job(10'd5, 10'd7, 10'd2);
      repeat (5) @(posedge clk);
      #1;
      check("wait_no_pop", 32'(n_fre - b_fre), 32'd0);
      check("wait_busy", 32'(busy), 32'd1);
      fifo_empty = 1'b0;
      drop = cyc;
      wait_end(200);
      check_job(10'd5, 10'd7, 2);
      check("pop_cyc", 32'(fre_cyc), 32'(drop + 1));

      // Zero-length job
      snap();
      start_job(10'd3, 10'd4, 10'd0);
      wait_end(100);
      check_job(10'd3, 10'd4, 0);

      // Address wrap on both sides
      snap();
      start_job(10'd1022, 10'd1023, 10'd3);
      wait_end(200);
      check_job(10'd1022, 10'd1023, 3);

      // Reset in the middle of FEED
      start_job(10'd50, 10'd60, 10'd8);
      for (int i = 0; i < 100 && !ub_rd; i++) begin
         @(posedge clk); #1;
      end
      check("feed_reached", 32'(ub_rd), 32'd1);
      @(posedge clk); #3;
      rstn = 1'b0;
      #1;
      check("rst_mid_outs", 32'({busy, end_, fifo_read_enable, we_rl, ub_rd, res_we, ub_addr, res_addr}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      snap();
      repeat (40) @(posedge clk);
      #1;
      check("no_wr_after_rst", 32'(wr_addr.size() - b_wr), 32'd0);
      check("idle_after_rst", 32'(busy), 32'd0);

      // Start re-pulsed while busy, including in the DONE cycle
      snap();
      start_job(10'd20, 10'd200, 10'd2);
      @(posedge clk); #1;
      in_base  = 10'd500;
      out_base = 10'd600;
      num_vec  = 10'd5;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 200 && !end_; i++) begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_in_done", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_job(10'd20, 10'd200, 2);
`ifdef TPU_SEQ_PERF_EN
      check("cycle_cnt", cycle_cnt, 32'(n_busy - b_busy));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tpu_seq_ctrl.md
TPU_SEQ_CTRL -- requirements
Module: tpu_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, 10, width of unified-buffer and result-SRAM addresses.
REQ-002 SHALL have parameter NUM_PE_ROWS, 8, number of we_rl cycles needed to shift one weight tile into the array.
REQ-003 SHALL have parameter RESULT_LAT, 17, cycles from a UB read address to the matching result vector at the array output.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle job request.
REQ-007 SHALL have ports in_base  input  ADDRESSSIZE  first UB address; out_base  input  ADDRESSSIZE  first result address; num_vec  input  ADDRESSSIZE  number of input vectors.
REQ-008 SHALL have port fifo_empty  input  1  weight FIFO empty flag.
REQ-009 SHALL have port fifo_read_enable  output  1  pops one weight tile.
REQ-010 SHALL have port we_rl  output  1  weight reload into the systolic array.
REQ-011 SHALL have ports ub_addr  output  ADDRESSSIZE  and ub_rd  output  1  UB read address and valid.
REQ-012 SHALL have ports res_addr  output  ADDRESSSIZE  and res_we  output  1  result-SRAM write address and enable.
REQ-013 SHALL have ports busy  output  1  and end_  output  1  (one-cycle job-complete pulse).

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT_W, LOAD_W, FEED, DRAIN, DONE.
REQ-015 In IDLE, start=1 SHALL latch in_base, out_base and num_vec and move to WAIT_W; start SHALL be ignored in every other state.
REQ-016 In WAIT_W, SHALL hold while fifo_empty=1; with fifo_empty=0 it SHALL assert fifo_read_enable for exactly one cycle and move to LOAD_W.
REQ-017 In LOAD_W, SHALL assert we_rl for exactly NUM_PE_ROWS consecutive cycles, then move to FEED, or to DONE if num_vec=0.
REQ-018 In FEED, SHALL assert ub_rd with ub_addr = in_base+i for i = 0..num_vec-1, one per cycle with no gaps, then move to DRAIN; addresses SHALL wrap modulo 2^ADDRESSSIZE.
REQ-019 SHALL assert res_we exactly RESULT_LAT cycles after each ub_rd, using a RESULT_LAT-deep valid shift register; res_addr SHALL equal out_base+j for the j-th write, also wrapping.
REQ-020 In DRAIN, SHALL move to DONE in the cycle after the num_vec-th res_we.
REQ-021 In DONE, SHALL assert end_ for one cycle and return to IDLE; a start in that cycle SHALL be ignored.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 fifo_read_enable, we_rl, ub_rd and res_we SHALL be driven from registers, never combinationally from inputs.

Reset
REQ-024 rstn=0 SHALL force state IDLE and all counters and the valid shift register to 0, and drive every output to 0, including mid-job; no res_we SHALL issue after reset.

Configuration
REQ-025 With TPU_SEQ_PERF_EN defined, SHALL add output cycle_cnt (32 bits), cleared on start acceptance, incremented each busy cycle, frozen at end_ and held until the next start; without the macro the port and its logic SHALL be absent.

Structure
REQ-026 The state encoding enum and the RESULT_LAT default SHALL live in shared package tpu_pkg.
REQ-027 The result-alignment delay SHALL be a sub-module tpu_valid_delay (parameter DEPTH, 1-bit in and out).

Verification
REQ-028 fifo_empty=0, num_vec=4, in_base=10, out_base=100: fifo_read_enable one cycle, we_rl 8 cycles, ub_addr 10..13, res_we at addresses 100..103 each 17 cycles after its read, then one end_ pulse.
REQ-029 fifo_empty=1 for 5 cycles after start: FSM stays in WAIT_W with no fifo_read_enable; it pops on the first cycle with empty=0.
REQ-030 num_vec=0: LOAD_W completes, there is no ub_rd or res_we, and end_ pulses.
REQ-031 in_base=1022, num_vec=3: ub_addr sequence 1022, 1023, 0.
REQ-032 rstn low during FEED: all outputs 0 immediately, and no res_we follows after release.
REQ-033 start re-pulsed while busy is ignored; with TPU_SEQ_PERF_EN defined, cycle_cnt equals the number of busy cycles.
